// File: rtl/data_ram_port_arbiter_if.sv
// Requester-side and RAM port-2 bus bundle for data_ram_port_arbiter.
// req_lock exists only when DATA_RAM_ARB_LOCK_EN is defined.
interface data_ram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
`ifdef DATA_RAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif

  logic [ADDR_W-1:0]         ram_address2;
  logic [BE_W-1:0]           ram_byteenable2;
  logic                      ram_chipselect2;
  logic                      ram_write2;
  logic [DATA_W-1:0]         ram_writedata2;
  logic                      ram_clken2;
  logic [DATA_W-1:0]         ram_readdata2;

  // Arbiter view: requests and RAM read data in, stalls and RAM controls out.
  modport slave (
`ifdef DATA_RAM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_address, req_byteenable, req_read, req_write, req_writedata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output ram_address2, ram_byteenable2, ram_chipselect2, ram_write2,
    output ram_writedata2, ram_clken2,
    input  ram_readdata2
  );

  modport master (
`ifdef DATA_RAM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_address, req_byteenable, req_read, req_write, req_writedata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  ram_address2, ram_byteenable2, ram_chipselect2, ram_write2,
    input  ram_writedata2, ram_clken2,
    output ram_readdata2
  );
endinterface

// File: rtl/data_ram_port_arbiter.sv
// Round-robin arbiter sharing data RAM port 2 between NUM_REQ Avalon-MM requesters.
// Define DATA_RAM_ARB_LOCK_EN to let a requester hold the port across several grants.
module data_ram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic clk,
  input  logic reset,
  data_ram_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic               rd_pend;
  logic [PTR_W-1:0]   rd_tag;
  logic [NUM_REQ-1:0] requesting;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [PTR_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant_oh;
  logic [PTR_W-1:0]   next_ptr;

  assign requesting = bus.req_read | bus.req_write;

`ifdef DATA_RAM_ARB_LOCK_EN
  logic             lock_valid;
  logic [PTR_W-1:0] lock_owner;

  // A locked owner that is still requesting masks everyone else out.
  always_comb begin
    eligible = requesting;
    if (lock_valid && requesting[lock_owner]) begin
      eligible             = '0;
      eligible[lock_owner] = 1'b1;
    end
  end

  // Every grant re-evaluates the lock; a cycle with no grant means the owner went idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else if (grant_valid) begin
      lock_valid <= bus.req_lock[winner];
      lock_owner <= winner;
    end else begin
      lock_valid <= 1'b0;
    end
  end
`else
  assign eligible = requesting;
`endif

  // Descending scan so the nearest index at or after rr_ptr is written last and wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    winner      = '0;
    if (!reset) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (eligible[idx]) begin
          grant_valid = 1'b1;
          winner      = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_valid) grant_oh[winner] = 1'b1;
  end

  assign next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= '0;
    end else begin
      rd_pend <= grant_valid & bus.req_read[winner] & ~bus.req_write[winner];
      if (grant_valid) begin
        rr_ptr <= next_ptr;
        rd_tag <= winner;
      end
    end
  end

  // Write wins over a simultaneous read, so ram_write2 simply follows req_write.
  always_comb begin
    bus.ram_address2    = '0;
    bus.ram_byteenable2 = '0;
    bus.ram_writedata2  = '0;
    bus.ram_write2      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        bus.ram_address2    = bus.req_address[i*ADDR_W +: ADDR_W];
        bus.ram_byteenable2 = bus.req_byteenable[i*BE_W +: BE_W];
        bus.ram_writedata2  = bus.req_writedata[i*DATA_W +: DATA_W];
        bus.ram_write2      = bus.req_write[i];
      end
    end
    bus.ram_chipselect2   = grant_valid;
    bus.req_waitrequest   = reset ? '1 : (requesting & ~grant_oh);
    bus.req_readdatavalid = '0;
    if (rd_pend && !reset) bus.req_readdatavalid[rd_tag] = 1'b1;
  end

  assign bus.req_readdata = bus.ram_readdata2;
  assign bus.ram_clken2   = 1'b1;
endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// Randomized self-checking bench for data_ram_port_arbiter with a RAM model and a
// behavioural arbitration model; directed cases pin literal expectations.
`timescale 1ns/1ps
module tb_data_ram_port_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  data_ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5)     return 32'hDEADBEEF;
    if (i == 'h3FF) return 32'hAABBCCDD;
    return 32'h5A5A0000 ^ (i * 32'h01030507);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // RAM port-2 model: synchronous byte-enabled write, one-cycle registered read.
  logic [31:0] ram_mem [1024];
  logic [31:0] ram_rd;
  assign bus.ram_readdata2 = ram_rd;

  initial begin : ram_model
    for (int i = 0; i < 1024; i++) ram_mem[i] = init_word(i);
    ram_rd = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_chipselect2) begin
        if (bus.ram_write2) begin
          for (int b = 0; b < BE_W; b++)
            if (bus.ram_byteenable2[b]) ram_mem[bus.ram_address2][b*8 +: 8] <= bus.ram_writedata2[b*8 +: 8];
        end else begin
          ram_rd <= ram_mem[bus.ram_address2];
        end
      end
    end
  end

  // Behavioural model: pointer as an integer, modulo scan, shadow memory, pending read.
  initial begin : model_compare
    logic [31:0]        m_shadow [1024];
    int                 m_ptr, m_tag, w, idx;
    bit                 m_pend, g, m_lock_valid;
    int                 m_lock_owner;
    logic [31:0]        m_pend_data;
    logic [NUM_REQ-1:0] req, gnt, exp_wait, exp_rdv;
    logic [ADDR_W-1:0]  a;
    logic [BE_W-1:0]    be;
    logic [DATA_W-1:0]  wd;
    for (int i = 0; i < 1024; i++) m_shadow[i] = init_word(i);
    m_ptr = 0; m_tag = 0; m_pend = 0; m_pend_data = '0;
    m_lock_valid = 0; m_lock_owner = 0;
    forever begin
      @(negedge clk);
      req = bus.req_read | bus.req_write;
      g = 0; w = 0;
      if (!reset) begin
`ifdef DATA_RAM_ARB_LOCK_EN
        if (m_lock_valid && req[m_lock_owner]) begin g = 1; w = m_lock_owner; end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (!g && req[idx]) begin g = 1; w = idx; end
        end
      end
      gnt      = g ? NUM_REQ'(1 << w) : '0;
      exp_wait = reset ? '1 : (req & ~gnt);
      exp_rdv  = (m_pend && !reset) ? NUM_REQ'(1 << m_tag) : '0;
      a  = bus.req_address[w*ADDR_W +: ADDR_W];
      be = bus.req_byteenable[w*BE_W +: BE_W];
      wd = bus.req_writedata[w*DATA_W +: DATA_W];

      checkOutput("waitrequest", bus.req_waitrequest, exp_wait);
      checkOutput("chipselect", bus.ram_chipselect2, g);
      checkOutput("ram_write", bus.ram_write2, g && bus.req_write[w]);
      checkOutput("readdatavalid", bus.req_readdatavalid, exp_rdv);
      if (m_pend && !reset) checkOutput("readdata", bus.req_readdata, m_pend_data);
      if (g) begin
        checkOutput("address", bus.ram_address2, a);
        checkOutput("byteenable", bus.ram_byteenable2, be);
        if (bus.req_write[w]) checkOutput("writedata", bus.ram_writedata2, wd);
      end

      if (reset) begin
        m_ptr = 0; m_pend = 0; m_lock_valid = 0;
      end else begin
        m_pend = g && bus.req_read[w] && !bus.req_write[w];
        if (m_pend) begin m_tag = w; m_pend_data = m_shadow[a]; end
        if (g && bus.req_write[w])
          for (int b = 0; b < BE_W; b++)
            if (be[b]) m_shadow[a][b*8 +: 8] = wd[b*8 +: 8];
        if (g) m_ptr = (w + 1) % NUM_REQ;
`ifdef DATA_RAM_ARB_LOCK_EN
        if (g) begin m_lock_valid = bus.req_lock[w]; m_lock_owner = w; end
        else m_lock_valid = 0;
`endif
      end
    end
  end

  task automatic clearReqs();
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_address    = '0;
    bus.req_byteenable = '0;
    bus.req_writedata  = '0;
`ifdef DATA_RAM_ARB_LOCK_EN
    bus.req_lock       = '0;
`endif
  endtask

  task automatic applyStimulus(input bit rst);
    @(posedge clk);
    #1;
    reset = rst;
    clearReqs();
  endtask

  task automatic setReq(input int i, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    bus.req_read[i]                        = rd;
    bus.req_write[i]                       = wr;
    bus.req_address[i*ADDR_W +: ADDR_W]    = a;
    bus.req_byteenable[i*BE_W +: BE_W]     = be;
    bus.req_writedata[i*DATA_W +: DATA_W]  = d;
  endtask

  logic [NUM_REQ-1:0] rr_wait [6];
  int                 wait_cnt [NUM_REQ];

  initial begin : stimulus
    int v;
    rr_wait = '{3'b110, 3'b101, 3'b011, 3'b110, 3'b101, 3'b011};
    clearReqs();

    // Reset with everyone requesting: all stalled, no RAM access.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1);
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, 0, 10'(i), 4'hF, '0);
      #2;
      checkOutput("reset_wait", bus.req_waitrequest, 3'b111);
      checkOutput("reset_cs", bus.ram_chipselect2, 1'b0);
      checkOutput("reset_rdv", bus.req_readdatavalid, 3'b000);
    end
    applyStimulus(0);
    #2;
    checkOutput("idle_cs", bus.ram_chipselect2, 1'b0);
    checkOutput("clken", bus.ram_clken2, 1'b1);

    // Single read by requester 1 of the preloaded word.
    applyStimulus(0);
    setReq(1, 1, 0, 10'h005, 4'hF, '0);
    #2;
    checkOutput("single_wait", bus.req_waitrequest, 3'b000);
    checkOutput("single_addr", bus.ram_address2, 10'h005);
    applyStimulus(0);
    #2;
    checkOutput("single_rdv", bus.req_readdatavalid, 3'b010);
    checkOutput("single_data", bus.req_readdata, 32'hDEADBEEF);

    // One grant to requester 2 wraps the pointer back to 0.
    applyStimulus(0);
    setReq(2, 1, 0, 10'h006, 4'hF, '0);
    #2;
    checkOutput("wrap_wait", bus.req_waitrequest, 3'b000);

    // Continuous requests from all three: strict 0,1,2 rotation.
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0);
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, 0, 10'(32'h100 + c*3 + i), 4'hF, '0);
      #2;
      checkOutput($sformatf("rr_wait%0d", c), bus.req_waitrequest, rr_wait[c]);
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] += int'(bus.req_waitrequest[i]);
    end
    for (int i = 0; i < NUM_REQ; i++) checkOutput($sformatf("rr_waitcount%0d", i), 64'(wait_cnt[i]), 64'd4);

    // Byte write to 0x3FF by requester 2, then read back by requester 0.
    applyStimulus(0);
    setReq(2, 0, 1, 10'h3FF, 4'b0100, 32'h11223344);
    #2;
    checkOutput("bytewr_write", bus.ram_write2, 1'b1);
    checkOutput("bytewr_be", bus.ram_byteenable2, 4'b0100);
    applyStimulus(0);
    setReq(0, 1, 0, 10'h3FF, 4'hF, '0);
    #2;
    applyStimulus(0);
    #2;
    checkOutput("bytewr_rdv", bus.req_readdatavalid, 3'b001);
    checkOutput("bytewr_data", bus.req_readdata, 32'hAA22CCDD);

    // Read and write together: the write is done and no read returns.
    applyStimulus(0);
    setReq(0, 1, 1, 10'h010, 4'hF, 32'h0BADF00D);
    #2;
    checkOutput("rw_write", bus.ram_write2, 1'b1);
    applyStimulus(0);
    #2;
    checkOutput("rw_rdv", bus.req_readdatavalid, 3'b000);

    // Reset right after a granted read swallows the return and clears the pointer.
    applyStimulus(0);
    setReq(0, 1, 0, 10'h020, 4'hF, '0);
    #2;
    applyStimulus(1);
    #2;
    checkOutput("rstrd_rdv", bus.req_readdatavalid, 3'b000);
    applyStimulus(0);
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, 0, 10'(32'h30 + i), 4'hF, '0);
    #2;
    checkOutput("rstrd_ptr0", bus.req_waitrequest, 3'b110);

    // Randomized traffic with a small address window to provoke read-after-write hits.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        v = $urandom_range(0, 7);
        setReq(i, (v >= 3 && v <= 5) || v == 7, v >= 6, 10'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 10'h3F8 : 10'h000),
               4'($urandom_range(0, 15)), $urandom);
`ifdef DATA_RAM_ARB_LOCK_EN
        bus.req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
      end
    end

`ifdef DATA_RAM_ARB_LOCK_EN
    // Requester 1 locks the port for four reads while 0 and 2 wait; 2 is next.
    applyStimulus(1);
    applyStimulus(0);
    applyStimulus(0);
    setReq(1, 1, 0, 10'h040, 4'hF, '0);
    bus.req_lock[1] = 1'b1;
    #2;
    checkOutput("lock_first", bus.req_waitrequest, 3'b000);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0);
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 1, 0, 10'(32'h41 + c*3 + i), 4'hF, '0);
      bus.req_lock[1] = 1'b1;
      #2;
      checkOutput($sformatf("lock_hold%0d", c), bus.req_waitrequest, 3'b101);
    end
    applyStimulus(0);
    setReq(0, 1, 0, 10'h050, 4'hF, '0);
    setReq(2, 1, 0, 10'h052, 4'hF, '0);
    #2;
    checkOutput("lock_release", bus.req_waitrequest, 3'b001);
`endif

    applyStimulus(0);
    applyStimulus(0);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
